// File: rtl/weight_fetch.sv
// weight_fetch: sequencer and output register between the kernel-weight ROM
// (weightGen) and the depthwise convolution engine.
//   i_clk, i_rst (async, active high), i_start/i_stop, i_first/i_last (range)
//   o_opcode -> ROM address, i_weight0..2 <- ROM rows
//   o_valid/i_ready beat handshake carrying o_weight0..2, o_kidx, o_last
//   o_busy, o_done (pulse), o_err (pulse on rejected start)
// Build option: define WEIGHT_LOOP_EN to repeat the programmed range until
// i_stop or reset.
module weight_fetch #(
  parameter int NUM_KERNELS = 38,
  parameter int OPW         = 6,
  parameter int WW          = 90
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic           i_stop,
  input  logic [OPW-1:0] i_first,
  input  logic [OPW-1:0] i_last,
  output logic [OPW-1:0] o_opcode,
  input  logic [WW-1:0]  i_weight0,
  input  logic [WW-1:0]  i_weight1,
  input  logic [WW-1:0]  i_weight2,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [WW-1:0]  o_weight0,
  output logic [WW-1:0]  o_weight1,
  output logic [WW-1:0]  o_weight2,
  output logic [OPW-1:0] o_kidx,
  output logic           o_last,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [OPW:0] NK = (OPW+1)'(NUM_KERNELS);

  state_t         state_q, state_d;
  logic [OPW-1:0] opcode_q, opcode_d;
  logic [OPW-1:0] first_q, first_d;
  logic [OPW-1:0] last_q, last_d;
  logic           valid_q, valid_d;
  logic [WW-1:0]  w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
  logic [OPW-1:0] kidx_q, kidx_d;
  logic           beat_last_q, beat_last_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           range_ok;

  assign range_ok = (i_first <= i_last) && ({1'b0, i_last} < NK);

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    first_d     = first_q;
    last_d      = last_q;
    valid_d     = valid_q;
    w0_d        = w0_q;
    w1_d        = w1_q;
    w2_d        = w2_q;
    kidx_d      = kidx_q;
    beat_last_d = beat_last_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (range_ok) begin
            first_d  = i_first;
            last_d   = i_last;
            opcode_d = i_first;
            state_d  = ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
`ifdef WEIGHT_LOOP_EN
        if (valid_q && i_ready && beat_last_q) done_d = 1'b1;
`endif
        if (!valid_q || i_ready) begin
          w0_d        = i_weight0;
          w1_d        = i_weight1;
          w2_d        = i_weight2;
          kidx_d      = opcode_q;
          beat_last_d = (opcode_q == last_q);
          valid_d     = 1'b1;
          if (opcode_q == last_q) begin
`ifdef WEIGHT_LOOP_EN
            opcode_d = first_q;
`else
            state_d = ST_DRAIN;
`endif
          end else begin
            opcode_d = opcode_q + OPW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (i_ready) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides whatever the state logic above decided this cycle.
    if (i_stop && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      valid_d     = 1'b0;
      opcode_d    = opcode_q;
      w0_d        = w0_q;
      w1_d        = w1_q;
      w2_d        = w2_q;
      kidx_d      = kidx_q;
      beat_last_d = beat_last_q;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      opcode_q    <= '0;
      first_q     <= '0;
      last_q      <= '0;
      valid_q     <= 1'b0;
      w0_q        <= '0;
      w1_q        <= '0;
      w2_q        <= '0;
      kidx_q      <= '0;
      beat_last_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      first_q     <= first_d;
      last_q      <= last_d;
      valid_q     <= valid_d;
      w0_q        <= w0_d;
      w1_q        <= w1_d;
      w2_q        <= w2_d;
      kidx_q      <= kidx_d;
      beat_last_q <= beat_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign o_opcode  = opcode_q;
  assign o_valid   = valid_q;
  assign o_weight0 = w0_q;
  assign o_weight1 = w1_q;
  assign o_weight2 = w2_q;
  assign o_kidx    = kidx_q;
  assign o_last    = beat_last_q;
  assign o_busy    = (state_q != ST_IDLE);
  assign o_done    = done_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_weight_fetch.sv
// tb_weight_fetch: directed and randomized bench for weight_fetch with a
// behavioural ROM and a beat-list model of the expected kernel sequence.
// Define WEIGHT_LOOP_EN to exercise the looping build.
module tb_weight_fetch;

  localparam int NK  = 38;
  localparam int OPW = 6;
  localparam int WW  = 90;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic           i_start;
  logic           i_stop;
  logic [OPW-1:0] i_first;
  logic [OPW-1:0] i_last;
  logic [OPW-1:0] o_opcode;
  logic [WW-1:0]  i_weight0, i_weight1, i_weight2;
  logic           o_valid;
  logic           i_ready;
  logic [WW-1:0]  o_weight0, o_weight1, o_weight2;
  logic [OPW-1:0] o_kidx;
  logic           o_last;
  logic           o_busy;
  logic           o_done;
  logic           o_err;

  logic [WW-1:0] rom0 [NK];
  logic [WW-1:0] rom1 [NK];
  logic [WW-1:0] rom2 [NK];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  assign i_weight0 = (int'(o_opcode) < NK) ? rom0[o_opcode] : '0;
  assign i_weight1 = (int'(o_opcode) < NK) ? rom1[o_opcode] : '0;
  assign i_weight2 = (int'(o_opcode) < NK) ? rom2[o_opcode] : '0;

  weight_fetch #(.NUM_KERNELS(NK), .OPW(OPW), .WW(WW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
    .i_first(i_first), .i_last(i_last), .o_opcode(o_opcode),
    .i_weight0(i_weight0), .i_weight1(i_weight1), .i_weight2(i_weight2),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_weight0(o_weight0), .o_weight1(o_weight1), .o_weight2(o_weight2),
    .o_kidx(o_kidx), .o_last(o_last), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input int k, input bit is_last);
    chk("kidx", 96'(o_kidx), 96'(k));
    chk("weight0", 96'(o_weight0), 96'(rom0[k]));
    chk("weight1", 96'(o_weight1), 96'(rom1[k]));
    chk("weight2", 96'(o_weight2), 96'(rom2[k]));
    chk("last", 96'(o_last), 96'(is_last));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, 96'(o_valid), 96'(0));
    chk({tag, "_busy"}, 96'(o_busy), 96'(0));
    chk({tag, "_done"}, 96'(o_done), 96'(0));
  endtask

  task automatic start_err(input int f, input int l);
    @(negedge i_clk);
    i_first = OPW'(f); i_last = OPW'(l); i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("err_pulse", 96'(o_err), 96'(1));
    chk("err_busy", 96'(o_busy), 96'(0));
    chk("err_valid", 96'(o_valid), 96'(0));
    @(negedge i_clk);
    chk("err_once", 96'(o_err), 96'(0));
    chk("err_busy2", 96'(o_busy), 96'(0));
  endtask

  // rmode: 0 ready always high, 1 ready pattern 1,0,0, 2 random ready.
  // stop_hs / rst_hs: abort by i_stop / i_rst once that many beats accepted.
  task automatic run_pass(input int f, input int l, input int rmode,
                          input int stop_hs, input int rst_hs);
    int exp_q[$];
    int n, acc, op_hold;
    bit finished, prev_stall, r;
    logic [OPW-1:0] s_kidx;
    logic [WW-1:0]  s_w0;
    logic           s_last;
    for (int k = f; k <= l; k++) exp_q.push_back(k);
    n = exp_q.size();
    acc = 0; finished = 0; prev_stall = 0;
    s_kidx = '0; s_w0 = '0; s_last = 1'b0;
    @(negedge i_clk);
    i_first = OPW'(f); i_last = OPW'(l); i_start = 1'b1; i_ready = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("start_opcode", 96'(o_opcode), 96'(f));
    chk("start_busy", 96'(o_busy), 96'(1));
    chk("start_valid", 96'(o_valid), 96'(0));
    i_first = OPW'($urandom_range(0, 63));
    i_last  = OPW'($urandom_range(0, 63));
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) @(negedge i_clk);
      chk("op_range", 96'(int'(o_opcode) < NK), 96'(1));
      if (acc == n) begin
        chk("done_pulse", 96'(o_done), 96'(1));
        chk("done_valid", 96'(o_valid), 96'(0));
        chk("done_busy", 96'(o_busy), 96'(0));
        if (rmode == 0) chk("pass_cycles", 96'(cyc), 96'(n + 1));
        finished = 1;
        break;
      end
      chk("no_early_done", 96'(o_done), 96'(0));
      if (rmode == 0) chk("valid_stream", 96'(o_valid), 96'(cyc >= 1));
      if (o_valid) begin
        chk_beat(exp_q[acc], acc == n - 1);
        if (prev_stall) begin
          chk("stall_kidx", 96'(o_kidx), 96'(s_kidx));
          chk("stall_w0", 96'(o_weight0), 96'(s_w0));
          chk("stall_last", 96'(o_last), 96'(s_last));
        end
      end
      if (acc == stop_hs) begin
        op_hold = int'(o_opcode);
        i_stop = 1'b1; i_start = 1'b0;
        @(negedge i_clk);
        i_stop = 1'b0;
        chk_idle_outputs("stop");
        chk("stop_opcode", 96'(o_opcode), 96'(op_hold));
        @(negedge i_clk);
        chk_idle_outputs("stop_after");
        return;
      end
      if (acc == rst_hs) begin
        i_start = 1'b0;
        #2 i_rst = 1'b1;
        #1;
        chk_idle_outputs("rst_mid");
        chk("rst_opcode", 96'(o_opcode), 96'(0));
        chk("rst_kidx", 96'(o_kidx), 96'(0));
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk_idle_outputs("rst_after");
        return;
      end
      case (rmode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom % 2);
      endcase
      i_ready = r;
      i_start = 1'($urandom % 2);
      prev_stall = o_valid && !r;
      s_kidx = o_kidx; s_w0 = o_weight0; s_last = o_last;
      if (o_valid && r) acc++;
    end
    i_start = 1'b0;
    chk("pass_finished", 96'(finished), 96'(1));
    chk("beat_count", 96'(acc), 96'(n));
  endtask

  // Looping build: beat j carries kernel f + j mod n; done follows each
  // accepted end-of-range beat.
  task automatic run_loop(input int f, input int l, input int beats);
    int n, acc;
    bit prev_end;
    n = l - f + 1; acc = 0; prev_end = 0;
    @(negedge i_clk);
    i_first = OPW'(f); i_last = OPW'(l); i_start = 1'b1; i_ready = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("loop_opcode", 96'(o_opcode), 96'(f));
    for (int cyc = 0; cyc <= beats; cyc++) begin
      if (cyc > 0) @(negedge i_clk);
      chk("loop_valid", 96'(o_valid), 96'(cyc >= 1));
      chk("loop_done", 96'(o_done), 96'(prev_end));
      if (o_valid) chk_beat(f + acc % n, (acc % n) == n - 1);
      prev_end = o_valid && ((acc % n) == n - 1);
      if (o_valid) acc++;
    end
    i_stop = 1'b1;
    @(negedge i_clk);
    i_stop = 1'b0;
    chk_idle_outputs("loop_stop");
    @(negedge i_clk);
    chk_idle_outputs("loop_stop_after");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NK; k++) begin
      rom0[k] = WW'({$urandom(), $urandom(), $urandom()});
      rom1[k] = WW'({$urandom(), $urandom(), $urandom()});
      rom2[k] = WW'({$urandom(), $urandom(), $urandom()});
    end
    rom0[0]  = 90'h28647515897477928427;
    rom1[0]  = 90'h60594996201193271552;
    rom2[0]  = 90'h47266548480648402887;
    rom0[37] = 90'h55586487683777192405;

    i_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0;
    i_first = '0; i_last = '0; i_ready = 1'b0;
    #12;
    chk("rst_opcode", 96'(o_opcode), 96'(0));
    chk("rst_valid", 96'(o_valid), 96'(0));
    chk("rst_w0", 96'(o_weight0), 96'(0));
    chk("rst_w1", 96'(o_weight1), 96'(0));
    chk("rst_w2", 96'(o_weight2), 96'(0));
    chk("rst_kidx", 96'(o_kidx), 96'(0));
    chk("rst_last", 96'(o_last), 96'(0));
    chk("rst_busy", 96'(o_busy), 96'(0));
    chk("rst_done", 96'(o_done), 96'(0));
    chk("rst_err", 96'(o_err), 96'(0));
    @(negedge i_clk);
    i_rst = 1'b0;

    start_err(9, 3);
    start_err(0, 40);

`ifdef WEIGHT_LOOP_EN
    run_loop(36, 37, 9);
    run_loop(2, 2, 4);
    run_loop(0, 37, 45);
    @(negedge i_clk);
    i_first = OPW'(0); i_last = OPW'(37); i_start = 1'b1; i_ready = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    chk_idle_outputs("loop_rst");
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk_idle_outputs("loop_rst_after");
    run_loop(5, 7, 7);
`else
    run_pass(0, 0, 0, -1, -1);
    chk("lit_w0", 96'(o_weight0), 96'(90'h28647515897477928427));
    run_pass(0, 37, 0, -1, -1);
    chk("lit_w37", 96'(o_weight0), 96'(90'h55586487683777192405));
    run_pass(5, 8, 1, -1, -1);
    run_pass(0, 37, 0, 3, -1);
    run_pass(2, 2, 0, -1, -1);
    run_pass(0, 37, 2, -1, 4);
    run_pass(2, 2, 0, -1, -1);
    for (int t = 0; t < 6; t++) begin
      int f, l;
      f = $urandom_range(0, NK - 1);
      l = $urandom_range(f, NK - 1);
      run_pass(f, l, 2, -1, -1);
    end
    run_pass(30, 37, 1, 2, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/weight_fetch.md
# weight_fetch

Sequencer and output register between the 38-entry combinational kernel-weight ROM (`weightGen`) and the depthwise convolution engine. It drives the ROM opcode and walks a programmed kernel range. Each ROM word (three 90-bit weight rows) is registered and presented to the conv engine over a valid/ready handshake, at up to one kernel per clock.

## Interface
Parameters:
- `NUM_KERNELS`, 38: number of valid ROM entries; opcodes `0..NUM_KERNELS-1`.
- `OPW`, 6: opcode width.
- `WW`, 90: width of one weight row.

Ports:
- `i_clk`, in, 1: single clock, rising edge.
- `i_rst`, in, 1: asynchronous, active-high reset.
- `i_start`, in, 1: start request, sampled only in IDLE.
- `i_stop`, in, 1: synchronous abort.
- `i_first`, in, `OPW`: first kernel index of the range.
- `i_last`, in, `OPW`: last kernel index of the range, inclusive.
- `o_opcode`, out, `OPW`: registered ROM address; drives `weightGen.i_opcode`.
- `i_weight0/1/2`, in, `WW`: ROM outputs, combinational on `o_opcode`.
- `o_valid`, out, 1: output beat valid.
- `i_ready`, in, 1: downstream accepts the beat.
- `o_weight0/1/2`, out, `WW`: registered weight rows.
- `o_kidx`, out, `OPW`: kernel index of the current beat.
- `o_last`, out, 1: the current beat is kernel `i_last`.
- `o_busy`, out, 1: state is not IDLE.
- `o_done`, out, 1: one-cycle pulse after the final beat is accepted.
- `o_err`, out, 1: one-cycle pulse when a start request is rejected.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE, `i_start=1`:
  - Range check: `i_first<=i_last` and `i_last<NUM_KERNELS`.
  - Pass: latch `i_first` and `i_last` internally, set `o_opcode<=i_first`, go to RUN.
  - Fail: pulse `o_err`, stay in IDLE.
- Load condition: state is RUN and (`!o_valid || i_ready`). On a load:
  - `o_weightN<=i_weightN`, `o_kidx<=o_opcode`, `o_last<=(o_opcode==last)`, `o_valid<=1`.
  - If `o_opcode==last`, go to DRAIN; otherwise `o_opcode<=o_opcode+1`.
- DRAIN: hold the final beat until `i_ready`. Then `o_valid<=0`, pulse `o_done`, go to IDLE.
- A handshake with no load in the same cycle clears `o_valid`.
- While `o_valid=1 && i_ready=0`, `o_weight*`, `o_kidx` and `o_last` hold stable.
- `i_start` outside IDLE is ignored.
- `i_stop`, any state other than IDLE:
  - Next edge: `o_valid<=0`, state IDLE, `o_opcode` unchanged.
  - No `o_done` pulse.
  - `i_stop` has priority over a same-cycle load.
- `i_first`/`i_last` changes after start do not affect the running pass.
- `o_opcode` never leaves `0..NUM_KERNELS-1`.

## Timing
- Reset (async assert, released on a clock edge): `o_opcode=0`, `o_valid=0`, `o_weight*=0`, `o_kidx=0`, `o_last=0`, `o_busy=0`, `o_done=0`, `o_err=0`, state IDLE.
- Latency:
  - Start sampled at edge E0.
  - `o_opcode=first` after E0.
  - First `o_valid` after E1.
- Throughput: with `i_ready` held at 1, one beat per cycle. A range of N kernels gives `o_valid` for N cycles, with `o_done` in the cycle after the final handshake.
- `o_err` and `o_done` are registered single-cycle pulses.
- Reset asserted mid-pass aborts immediately; the block restarts only on a new `i_start`.

## Configuration
- Macro: `WEIGHT_LOOP_EN`.
- Defined:
  - A load with `o_opcode==last` wraps `o_opcode<=first` and stays in RUN, so passes repeat without a bubble.
  - `o_last` marks each pass end.
  - `o_done` pulses on each accepted last beat.
  - Only `i_stop` or reset ends operation.
- Undefined: a single pass, as described in Operation.

## Test plan
- Reset, then `i_start` with `first=0`, `last=0`, `i_ready=1` -> one beat after 2 edges with `o_weight0=90'h28647515897477928427`, `o_weight1=90'h60594996201193271552`, `o_weight2=90'h47266548480648402887`, `o_kidx=0`, `o_last=1`; `o_done` pulses the next cycle.
- Full range `first=0`, `last=37`, `i_ready=1` -> 38 consecutive beats, `o_kidx` 0..37; the final beat has `o_weight0=90'h55586487683777192405` and `o_last=1`.
- Range 5..8 with `i_ready` toggling 1,0,0,1,… -> exactly 4 beats, kidx 5,6,7,8; data stable while stalled; no skips or duplicates.
- `i_start` with `first=9`, `last=3` and with `last=40` -> `o_err` pulse each time, `o_valid` stays 0, `o_busy` stays 0.
- Range 0..37 with `i_stop` after the third handshake, and separately `i_rst` mid-pass -> `o_valid=0` next edge, no `o_done`; a new start of 2..2 yields a single kidx-2 beat.
- With `WEIGHT_LOOP_EN` and range 36..37 -> kidx sequence 36,37,36,37,… with no gap, `o_last` on each 37; `i_stop` ends the sequence.
